sram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one single-port synchronous SRAM (1-cycle read latency, active-low CSN/WEN) between two requesters, e.g. the weight/activation loader and the MAC-array fetch unit. It issues at most one access per cycle and routes each read response back to the requester that issued it. A bounded LOCK mechanism lets a requester hold priority for short bursts without starving the other.

---
 rtl/sram_arbiter.sv | 72 +++++++
 tb/tb_sram_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one single-port synchronous SRAM between two requesters
// Ports: CLK/RST (async, active high); per port x: REQx/WEx/LOCKx/Ax/DIx in, GNTx/RVALIDx/RDATAx out;
// SRAM side: CSN/WEN/A/DI out (active-low CSN/WEN), DOUT in (1-cycle read latency).
module sram_arbiter #(
  parameter int BW = 32,
  parameter int AW = 4,
  parameter int MAX_LOCK = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic          LOCK0,
  input  logic          LOCK1,
  input  logic [AW-1:0] A0,
  input  logic [AW-1:0] A1,
  input  logic [BW-1:0] DI0,
  input  logic [BW-1:0] DI1,
  output logic          GNT0,
  output logic          GNT1,
  output logic          RVALID0,
  output logic          RVALID1,
  output logic [BW-1:0] RDATA0,
  output logic [BW-1:0] RDATA1,
  output logic          CSN,
  output logic          WEN,
  output logic [AW-1:0] A,
  output logic [BW-1:0] DI,
  input  logic [BW-1:0] DOUT
);
  localparam int LW = MAX_LOCK > 1 ? $clog2(MAX_LOCK) : 1;
  localparam logic [LW-1:0] LMAX = LW'(MAX_LOCK - 1);
  logic          ptr;
  logic [LW-1:0] lcnt;
  logic          rpend;
  logic          rport;
  logic          gnt;
  logic          sel;
  logic          we_sel;
  logic          hold;
  // Grants are gated by RST so nothing reaches the SRAM while reset is held.
  assign GNT0   = ~RST & REQ0 & (~REQ1 | ~ptr);
  assign GNT1   = ~RST & REQ1 & (~REQ0 | ptr);
  assign gnt    = GNT0 | GNT1;
  // With no grant sel is 0, so the SRAM bus idles on the port-0 values.
  assign sel    = GNT1;
  assign we_sel = sel ? WE1 : WE0;
  assign hold   = (sel ? LOCK1 : LOCK0) && lcnt < LMAX;
  assign CSN    = ~gnt;
  assign WEN    = ~we_sel;
  assign A      = sel ? A1 : A0;
  assign DI     = sel ? DI1 : DI0;
  assign RVALID0 = rpend & ~rport;
  assign RVALID1 = rpend & rport;
  assign RDATA0  = DOUT;
  assign RDATA1  = DOUT;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr   <= 1'b0;
      lcnt  <= '0;
      rpend <= 1'b0;
      rport <= 1'b0;
    end else begin
      ptr   <= gnt ? (hold ? sel : ~sel) : ptr;
      lcnt  <= gnt && hold ? lcnt + LW'(1) : '0;
      rpend <= gnt & ~we_sel;
      rport <= sel;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed table, corner sequences and random traffic against a reference model
module tb_sram_arbiter;
  localparam int BW = 32;
  localparam int AW = 4;
  localparam int ML = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ0 = 0, REQ1 = 0, WE0 = 0, WE1 = 0, LOCK0 = 0, LOCK1 = 0;
  logic [AW-1:0] A0 = '0, A1 = '0;
  logic [BW-1:0] DI0 = '0, DI1 = '0;
  logic          GNT0, GNT1, RVALID0, RVALID1, CSN, WEN;
  logic [BW-1:0] RDATA0, RDATA1, DI, DOUT;
  logic [AW-1:0] A;

  always #5 CLK = ~CLK;

  sram_arbiter #(.BW(BW), .AW(AW), .MAX_LOCK(ML)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1), .LOCK0(LOCK0), .LOCK1(LOCK1),
    .A0(A0), .A1(A1), .DI0(DI0), .DI1(DI1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .RDATA0(RDATA0), .RDATA1(RDATA1),
    .CSN(CSN), .WEN(WEN), .A(A), .DI(DI), .DOUT(DOUT)
  );

  logic [BW-1:0] mem [16] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                              32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777,
                              32'h88888888, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB,
                              32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};
  logic [BW-1:0] ref_mem [16] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                                  32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777,
                                  32'h88888888, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB,
                                  32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};

  always @(posedge CLK) begin
    if (!CSN) begin
      if (!WEN) mem[A] <= DI;
      else DOUT <= mem[A];
    end
  end

  int checks = 0;
  int failures = 0;

  logic          m_ptr = 1'b0;
  int            m_locks = 0;
  int            m_pend = -1;
  logic [BW-1:0] m_pdata = '0;
  logic          lg0 = 1'b0, lg1 = 1'b0;
  logic          s_g0, s_g1, s_v0, s_v1;
  logic [BW-1:0] s_rd;

  typedef struct {
    logic          pre;
    logic          r0, r1, w0, w1, l0, l1;
    logic [AW-1:0] a0, a1;
    logic [BW-1:0] d0, d1;
    logic          g0, g1, v0, v1;
    logic [BW-1:0] rd;
  } vec_t;
  vec_t vq[$];

  task automatic add(input vec_t v);
    vq.push_back(v);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 1'b0;
    m_locks = 0;
    m_pend = -1;
    lg0 = 1'b0;
    lg1 = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    #1;
    chk1("rst_gnt0", GNT0, 1'b0);
    chk1("rst_gnt1", GNT1, 1'b0);
    chk1("rst_csn", CSN, 1'b1);
    chk1("rst_rvalid0", RVALID0, 1'b0);
    chk1("rst_rvalid1", RVALID1, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    RST = 1'b0;
    model_reset();
  endtask

  // Called at a falling edge: drive, check mid-cycle, advance the model at the rising edge.
  task automatic cycle(input logic r0, r1, w0, w1, l0, l1,
                       input logic [AW-1:0] a0, a1, input logic [BW-1:0] d0, d1);
    logic eg0, eg1, wsel, lk;
    logic [AW-1:0] asel;
    REQ0 = r0; REQ1 = r1; WE0 = w0; WE1 = w1; LOCK0 = l0; LOCK1 = l1;
    A0 = a0; A1 = a1; DI0 = d0; DI1 = d1;
    #1;
    eg0 = r0 && (!r1 || !m_ptr);
    eg1 = r1 && (!r0 || m_ptr);
    wsel = eg1 ? w1 : w0;
    asel = eg1 ? a1 : a0;
    lk = eg1 ? l1 : l0;
    chk1("gnt0", GNT0, eg0);
    chk1("gnt1", GNT1, eg1);
    chk1("csn", CSN, !(eg0 || eg1));
    chk1("wen", WEN, !wsel);
    chk32("addr", {28'h0, A}, {28'h0, asel});
    chk32("di", DI, eg1 ? d1 : d0);
    chk1("rvalid0", RVALID0, m_pend == 0);
    chk1("rvalid1", RVALID1, m_pend == 1);
    if (m_pend >= 0) chk32("rdata", m_pend == 1 ? RDATA1 : RDATA0, m_pdata);
    s_g0 = GNT0; s_g1 = GNT1; s_v0 = RVALID0; s_v1 = RVALID1;
    s_rd = RVALID1 ? RDATA1 : RDATA0;
    @(posedge CLK);
    if (eg0 || eg1) begin
      if (lk && m_locks < ML - 1) begin
        m_ptr = eg1;
        m_locks++;
      end else begin
        m_ptr = !eg1;
        m_locks = 0;
      end
      if (wsel) begin
        ref_mem[asel] = eg1 ? d1 : d0;
        m_pend = -1;
      end else begin
        m_pend = eg1 ? 1 : 0;
        m_pdata = ref_mem[asel];
      end
    end else begin
      m_locks = 0;
      m_pend = -1;
    end
    lg0 = eg0;
    lg1 = eg1;
    @(negedge CLK);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 32'h0, 32'h0);
  endtask

  logic          pr[2], pw[2], pl[2];
  logic [AW-1:0] pa[2];
  logic [BW-1:0] pd[2];
  int            run;

  initial begin
    //       pre r0 r1 w0 w1 l0 l1  a0     a1     d0            d1            g0 g1 v0 v1 rd
    add('{1, 1, 0, 1, 0, 0, 0, 4'd3, 4'd0, 32'hA5A5A5A5, 32'h0,        1, 0, 0, 0, 32'h0});
    add('{0, 1, 0, 0, 0, 0, 0, 4'd3, 4'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0});
    add('{0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        0, 0, 1, 0, 32'hA5A5A5A5});
    add('{1, 1, 1, 0, 0, 0, 0, 4'd1, 4'd2, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0});
    add('{0, 1, 1, 0, 0, 0, 0, 4'd1, 4'd2, 32'h0,        32'h0,        0, 1, 1, 0, 32'h11111111});
    add('{0, 1, 1, 0, 0, 0, 0, 4'd1, 4'd2, 32'h0,        32'h0,        1, 0, 0, 1, 32'h22222222});
    add('{0, 1, 1, 0, 0, 0, 0, 4'd1, 4'd2, 32'h0,        32'h0,        0, 1, 1, 0, 32'h11111111});
    add('{0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h22222222});
    add('{1, 1, 1, 0, 0, 1, 0, 4'd1, 4'd2, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0});
    add('{0, 1, 1, 0, 0, 1, 0, 4'd1, 4'd2, 32'h0,        32'h0,        1, 0, 1, 0, 32'h11111111});
    add('{0, 1, 1, 0, 0, 1, 0, 4'd1, 4'd2, 32'h0,        32'h0,        1, 0, 1, 0, 32'h11111111});
    add('{0, 1, 1, 0, 0, 1, 0, 4'd1, 4'd2, 32'h0,        32'h0,        1, 0, 1, 0, 32'h11111111});
    add('{0, 1, 1, 0, 0, 1, 0, 4'd1, 4'd2, 32'h0,        32'h0,        0, 1, 1, 0, 32'h11111111});
    add('{0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h22222222});
    add('{1, 1, 0, 0, 0, 0, 0, 4'd5, 4'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0});
    add('{0, 1, 1, 0, 1, 0, 0, 4'd7, 4'd7, 32'h0,        32'h12345678, 0, 1, 1, 0, 32'h55555555});
    add('{0, 1, 0, 0, 0, 0, 0, 4'd7, 4'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0});
    add('{0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        0, 0, 1, 0, 32'h12345678});
    @(negedge CLK);
    foreach (vq[i]) begin
      if (vq[i].pre) do_reset();
      cycle(vq[i].r0, vq[i].r1, vq[i].w0, vq[i].w1, vq[i].l0, vq[i].l1,
            vq[i].a0, vq[i].a1, vq[i].d0, vq[i].d1);
      chk1("vec_gnt0", s_g0, vq[i].g0);
      chk1("vec_gnt1", s_g1, vq[i].g1);
      chk1("vec_rvalid0", s_v0, vq[i].v0);
      chk1("vec_rvalid1", s_v1, vq[i].v1);
      if (vq[i].v0 || vq[i].v1) chk32("vec_rdata", s_rd, vq[i].rd);
    end
    // Idle clears the lock count: after two locked grants and three idle cycles,
    // port 0 again gets the full four-grant burst before port 1 wins.
    do_reset();
    cycle(1, 1, 0, 0, 1, 0, 4'd4, 4'd6, 32'h0, 32'h0);
    cycle(1, 1, 0, 0, 1, 0, 4'd4, 4'd6, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk1("idle_csn", CSN, 1'b1);
    end
    run = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 0, 1, 0, 4'd4, 4'd6, 32'h0, 32'h0);
      if (s_g0) run++;
    end
    chk32("burst_after_idle", run, 4);
    chk1("burst_end_port1", s_g1, 1'b1);
    idle();
    // A read response in flight is discarded by an asynchronous reset.
    idle();
    cycle(0, 1, 0, 0, 0, 0, 4'd0, 4'd2, 32'h0, 32'h0);
    chk1("midrd_rvalid1_before", RVALID1, 1'b1);
    #1 RST = 1'b1;
    #1;
    chk1("midrd_rvalid1_rst", RVALID1, 1'b0);
    chk1("midrd_rvalid0_rst", RVALID0, 1'b0);
    @(posedge CLK);
    #1;
    chk1("midrd_rvalid1_hold", RVALID1, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    idle();
    chk1("post_rst_rvalid1", s_v1, 1'b0);
    idle();
    chk1("post_rst_csn", CSN, 1'b1);
    cycle(1, 1, 0, 0, 0, 0, 4'd9, 4'd10, 32'h0, 32'h0);
    chk1("post_rst_ptr0", s_g0, 1'b1);
    // Random traffic: a waiting port holds its request or withdraws it.
    for (int p = 0; p < 2; p++) begin
      pr[p] = 0; pw[p] = 0; pl[p] = 0; pa[p] = '0; pd[p] = '0;
    end
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (pr[p] && !(p == 1 ? lg1 : lg0)) begin
          if ($urandom_range(9) == 0) pr[p] = 1'b0;
        end else begin
          pr[p] = $urandom_range(9) < 7;
          pw[p] = 1'($urandom_range(1));
          pl[p] = $urandom_range(2) == 0;
          pa[p] = 4'($urandom_range(15));
          pd[p] = $urandom;
        end
      end
      cycle(pr[0], pr[1], pw[0], pw[1], pl[0], pl[1], pa[0], pa[1], pd[0], pd[1]);
    end
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
